// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_arb
//  Description : N-channel valid/ready stream multiplexer with a registered
//                output stage, packet locking and two selection modes:
//                explicit select (mode = 0) or round-robin (mode = 1).
//                One beat per clock while the consumer keeps out_ready high.
//
//  Ports
//    clk        : rising-edge clock
//    rst_n      : asynchronous active-low reset
//    mode       : 0 = explicit select via sel, 1 = round-robin arbitration
//    sel        : channel index used in explicit-select mode
//    in_valid   : per-channel valid (bit i = channel i)
//    in_data    : per-channel data, channel i at [i*WIDTH +: WIDTH]
//    in_last    : per-channel end-of-packet marker
//    in_ready   : per-channel ready, at most one bit high
//    out_valid  : output register holds a beat
//    out_data   : registered data
//    out_last   : registered end-of-packet marker
//    out_chan   : channel that supplied the current beat
//    out_ready  : consumer accepts the beat when high with out_valid
//
//  Revision    : 1.0  initial release
// ============================================================================
module stream_mux_arb #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    // Pointer reset value: the last channel, so channel 0 wins the first
    // round-robin arbitration.
    localparam logic [SEL_W-1:0] c_last_chan = SEL_W'(CHANNELS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [SEL_W-1:0]    r_lock_ch;
    logic [SEL_W-1:0]    r_ptr;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_last;
    logic [SEL_W-1:0]    r_out_chan;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t              w_state_next;
    logic                w_can_load;
    logic [CHANNELS-1:0] w_cand_oh;     // one-hot candidate, all-zero = none
    logic [SEL_W-1:0]    w_cand;        // binary index of the candidate
    logic                w_xfer;
    logic [WIDTH-1:0]    w_cand_data;
    logic                w_cand_last;
    int                  w_rr_idx;

    // The output stage can take a new beat when it is empty or being drained
    // in this same cycle.
    assign w_can_load = !r_out_valid || out_ready;

    // ------------------------------------------------------------------------
    // Candidate selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_cand_oh = '0;
        w_cand    = '0;
        w_rr_idx  = 0;
        if (r_state == ST_LOCKED) begin
            // Locked to the packet owner; its ready is offered even while
            // its valid is low so the packet can resume at any time.
            w_cand = r_lock_ch;
            for (int g = 0; g < CHANNELS; g++) begin
                if (r_lock_ch == SEL_W'(g)) begin
                    w_cand_oh[g] = 1'b1;
                end
            end
        end else if (!mode) begin
            // Explicit select. An out-of-range sel matches no channel, and
            // there is deliberately no fallback to another valid channel.
            for (int g = 0; g < CHANNELS; g++) begin
                if ((sel == SEL_W'(g)) && in_valid[g]) begin
                    w_cand_oh[g] = 1'b1;
                    w_cand       = sel;
                end
            end
        end else begin
            // Round-robin: search upward from ptr+1 with wrap. The loop runs
            // from the lowest priority offset to the highest so the final
            // assignment is the winner. ptr is always < CHANNELS, so one
            // subtraction is enough to wrap.
            for (int k = CHANNELS; k >= 1; k--) begin
                w_rr_idx = int'(r_ptr) + k;
                if (w_rr_idx >= CHANNELS) begin
                    w_rr_idx = w_rr_idx - CHANNELS;
                end
                if (in_valid[w_rr_idx]) begin
                    w_cand_oh           = '0;
                    w_cand_oh[w_rr_idx] = 1'b1;
                    w_cand              = SEL_W'(w_rr_idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ready generation. rst_n is folded in so no channel sees ready while the
    // block is held in reset.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ready
            assign in_ready[g] = w_can_load && w_cand_oh[g] && rst_n;
        end
    endgenerate

    assign w_xfer = |(in_valid & in_ready);

    // ------------------------------------------------------------------------
    // Data / last mux driven by the one-hot candidate
    // ------------------------------------------------------------------------
    always_comb begin
        w_cand_data = '0;
        w_cand_last = 1'b0;
        for (int g = 0; g < CHANNELS; g++) begin
            if (w_cand_oh[g]) begin
                w_cand_data = in_data[g*WIDTH +: WIDTH];
                w_cand_last = in_last[g];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_xfer) begin
            // A single-beat packet goes straight back to IDLE, so the lock
            // is only ever taken for multi-beat packets.
            w_state_next = w_cand_last ? ST_IDLE : ST_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Lock owner, round-robin pointer and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_ch   <= '0;
            r_ptr       <= c_last_chan;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
        end else begin
            if (w_xfer) begin
                r_lock_ch <= w_cand;
                // The granted channel becomes the lowest priority next time.
                r_ptr     <= w_cand;
            end
            if (w_can_load) begin
                r_out_valid <= w_xfer;
                // Payload fields keep their previous value on an empty cycle.
                if (w_xfer) begin
                    r_out_data <= w_cand_data;
                    r_out_last <= w_cand_last;
                    r_out_chan <= w_cand;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel streaming multiplexer with a registered output, valid/ready handshaking, packet locking and two selection modes: explicit select or round-robin arbitration. It generalises the team's fixed 4:1 select mux to any channel count and data width. It sits between multiple producer streams and a single consumer. Throughput is one beat per clock.

## Interface
- WIDTH, 8, data width per channel in bits (≥1)
- CHANNELS, 4, number of input channels (≥2; need not be a power of two)
- SEL_W, derived localparam = $clog2(CHANNELS); not overridable
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode = 0
- in_valid  input  CHANNELS  per-channel valid; bit i belongs to channel i
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  CHANNELS  per-channel end-of-packet marker
- in_ready  output  CHANNELS  per-channel ready; at most one bit is high in any cycle
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_last  output  1  registered end-of-packet marker
- out_chan  output  SEL_W  index of the channel that supplied the current beat
- out_ready  input  1  consumer accepts the beat when it is high together with out_valid

## Operation
- can_load = !out_valid || out_ready. The output register accepts a new beat only when can_load is high.
- State is IDLE or LOCKED(lock_ch). The round-robin pointer ptr holds the index of the last granted channel.
- Candidate channel in IDLE:
  - mode 0: candidate is sel, if sel < CHANNELS and in_valid[sel] = 1. Otherwise there is no candidate. There is no fallback to another channel.
  - mode 1: candidate is the first channel with in_valid high, searching upward from ptr+1 and wrapping modulo CHANNELS.
- Candidate channel in LOCKED: lock_ch only. mode, sel and the other channels' valid bits are ignored.
- in_ready[g] = can_load && (g is the candidate) && rst_n. In LOCKED, in_ready[lock_ch] is driven without regard to in_valid[lock_ch].
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. On a transfer:
  - out_data ← in_data slice g; out_last ← in_last[g]; out_chan ← g; out_valid ← 1; ptr ← g.
  - If in_last[g] = 0, next state is LOCKED(g). If in_last[g] = 1, next state is IDLE.
- No transfer with can_load high: out_valid ← 0. out_data, out_last and out_chan keep their last values.
- can_load low: all output registers hold and all in_ready bits are 0.
- Single-beat packets (in_last = 1 on the first beat) never enter LOCKED.
- A mode or sel change while LOCKED takes effect on the first arbitration after the last beat is accepted.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_last = 0, out_chan = 0.
  - in_ready = all zeros, state = IDLE, ptr = CHANNELS-1, so channel 0 wins the first round-robin arbitration.
- After rst_n deasserts, the first transfer can occur in the first clock edge.
- Latency: a beat transferred at edge k appears on out_* after edge k and is accepted at the first edge ≥ k+1 where out_ready = 1.
- Throughput: one beat per cycle while out_ready stays high. A back-to-back load and drain in the same cycle is legal, because can_load is high when out_ready is high.
- Backpressure: when out_valid = 1 and out_ready = 0, out_* stay stable and in_ready = 0.
- Arbitration across packets:
  - A new packet from a different channel may transfer in the cycle right after the last beat of the previous packet. There is no idle bubble.
  - In mode 1, a channel that just finished a packet has the lowest priority in the next arbitration.
- Reset asserted mid-packet: state returns to IDLE and the partial packet is abandoned. The producer is responsible for any recovery.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. No input valid may depend on in_ready.

## Test plan
- Reset and explicit select: CHANNELS = 4, WIDTH = 8, mode = 0, sel = 2, ch2 sends 0xA5 with last = 1, out_ready = 1 → out_data = 0xA5, out_chan = 2, out_last = 1 one cycle later. in_ready = 4'b0100 in the transfer cycle.
- Round-robin fairness: mode = 1, all four channels continuously valid with single-beat packets, out_ready = 1 → out_chan sequence is 0, 1, 2, 3, 0, 1, with one beat per cycle.
- Packet lock: mode = 1, ch1 sends a 3-beat packet (0x11, 0x12, 0x13 with last on the third) while ch0 and ch3 are valid → out_chan = 1 for 3 consecutive beats, then 3, then 0.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 → out_data stable and in_ready = 0. On release, the next beat follows with no beat lost or duplicated.
- Select edge cases: mode = 0 with sel = 1 and in_valid[1] = 0 while ch0 is valid → no transfer, out_valid = 0. A change of sel mid-packet is ignored until the last beat.
- Asynchronous reset mid-packet, with CHANNELS = 3 (non-power-of-two): all outputs go to zero immediately. The next arbitration in mode 1 grants channel 0.
